// File: rtl/bf16_pkg.sv
// Shared definitions for the bf16 sequencer: op codes, special values,
// response flag positions and the sequencer state encoding.
package bf16_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MUL  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
    localparam logic [15:0] BF16_POS_INF = 16'h7F80;
    localparam logic [15:0] BF16_NEG_INF = 16'hFF80;

    // Bit positions inside the 3-bit response flag vector {timeout, invalid, fast_path}.
    localparam int FLAG_FAST    = 0;
    localparam int FLAG_INVALID = 1;
    localparam int FLAG_TIMEOUT = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLASS     = 2'd1,
        ST_CORE_WAIT = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

endpackage

// File: rtl/bf16_operand_class.sv
// Combinational bf16 operand classifier. Subnormals are reported as zero
// because the sequencer flushes them to signed zero.
module bf16_operand_class (
    input  logic [15:0] operand_i,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_zero,
    output logic        is_normal,
    output logic        sign
);
    logic [7:0] w_exp;
    logic [6:0] w_man;

    assign w_exp     = operand_i[14:7];
    assign w_man     = operand_i[6:0];
    assign sign      = operand_i[15];
    assign is_nan    = (w_exp == 8'hFF) && (w_man != 7'd0);
    assign is_inf    = (w_exp == 8'hFF) && (w_man == 7'd0);
    assign is_zero   = (w_exp == 8'h00);
    assign is_normal = (w_exp != 8'h00) && (w_exp != 8'hFF);

endmodule

// File: rtl/bf16_fpu_sequencer.sv
// Single-issue request sequencer for the bf16 arithmetic core. Special
// operands are resolved locally; everything else is dispatched to the core
// and guarded by a watchdog that returns a quiet NaN on expiry.
module bf16_fpu_sequencer
    import bf16_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [15:0]      req_a_i,
    input  logic [15:0]      req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             core_start_o,
    output logic [1:0]       core_op_o,
    output logic [15:0]      core_a_o,
    output logic [15:0]      core_b_o,
    input  logic             core_done_i,
    input  logic [15:0]      core_result_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [15:0]      resp_result_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic [2:0]       resp_flags_o
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            r_state, w_next_state;
    op_e               r_op;
    logic [15:0]       r_a, r_b;
    logic [TAG_W-1:0]  r_tag;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_core_op;
    logic [15:0]       r_core_a, r_core_b;
    logic [15:0]       r_result;
    logic [2:0]        r_flags;

    logic              w_is_mul, w_is_sub;
    logic [15:0]       w_eff_b;
    logic [1:0]        w_dispatch_op;
    logic              w_a_nan, w_a_inf, w_a_zero, w_a_normal, w_a_sign;
    logic              w_b_nan, w_b_inf, w_b_zero, w_b_normal, w_b_sign;
    logic              w_fast, w_invalid;
    logic [15:0]       w_fast_result;
    logic              w_req_ready, w_dispatch, w_timeout;

    // SUB is handled as ADD of the sign-flipped B everywhere downstream.
    assign w_is_mul      = (r_op == OP_MUL);
    assign w_is_sub      = (r_op == OP_SUB);
    assign w_eff_b       = {r_b[15] ^ w_is_sub, r_b[14:0]};
    assign w_dispatch_op = w_is_mul ? OP_MUL : OP_ADD;

    bf16_operand_class u_class_a (
        .operand_i (r_a),
        .is_nan    (w_a_nan),
        .is_inf    (w_a_inf),
        .is_zero   (w_a_zero),
        .is_normal (w_a_normal),
        .sign      (w_a_sign)
    );

    bf16_operand_class u_class_b (
        .operand_i (w_eff_b),
        .is_nan    (w_b_nan),
        .is_inf    (w_b_inf),
        .is_zero   (w_b_zero),
        .is_normal (w_b_normal),
        .sign      (w_b_sign)
    );

    // Only a pair of normal operands needs the core.
    assign w_fast = ~(w_a_normal & w_b_normal);

    // Special-case result, evaluated in priority order.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_invalid     = 1'b0;
        w_fast_result = BF16_QNAN;
        if (w_a_nan || w_b_nan) begin
            w_fast_result = BF16_QNAN;
        end else if (!w_is_mul && w_a_inf && w_b_inf && (w_a_sign != w_b_sign)) begin
            w_invalid = 1'b1;
        end else if (w_is_mul && ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf))) begin
            w_invalid = 1'b1;
        end else if (!w_is_mul && w_a_inf) begin
            w_fast_result = r_a;
        end else if (!w_is_mul && w_b_inf) begin
            w_fast_result = w_eff_b;
        end else if (w_is_mul && (w_a_inf || w_b_inf)) begin
            w_fast_result = (w_a_sign ^ w_b_sign) ? BF16_NEG_INF : BF16_POS_INF;
        end else if (w_is_mul && (w_a_zero || w_b_zero)) begin
            w_fast_result = {w_a_sign ^ w_b_sign, 15'h0000};
        end else if (!w_is_mul && w_a_zero && w_b_zero) begin
            w_fast_result = {w_a_sign & w_b_sign, 15'h0000};
        end else if (!w_is_mul && w_a_zero) begin
            w_fast_result = w_eff_b;
        end else if (!w_is_mul && w_b_zero) begin
            w_fast_result = r_a;
        end
    end

    assign w_timeout = (r_cnt == CNT_LAST);

    // Next-state and handshake decode.
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 1'b0;
        w_dispatch   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid_i) w_next_state = ST_CLASS;
            end
            ST_CLASS: begin
                if (w_fast) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_dispatch   = 1'b1;
                    w_next_state = ST_CORE_WAIT;
                end
            end
            ST_CORE_WAIT: begin
                if (core_done_i || w_timeout) w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready_i) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // Request capture, core operand hold, watchdog counter and response registers.
    always_ff @(posedge clk_i) begin
        // NOTE: datapath registers are reset too, because they drive ports that must read 0 after reset.
        if (!rst_ni) begin
            r_op      <= OP_ADD;
            r_a       <= '0;
            r_b       <= '0;
            r_tag     <= '0;
            r_cnt     <= '0;
            r_core_op <= '0;
            r_core_a  <= '0;
            r_core_b  <= '0;
            r_result  <= '0;
            r_flags   <= '0;
        end else begin
            if (w_req_ready && req_valid_i) begin
                r_op  <= op_e'(req_op_i);
                r_a   <= req_a_i;
                r_b   <= req_b_i;
                r_tag <= req_tag_i;
            end
            if (w_dispatch) begin
                r_core_op <= w_dispatch_op;
                r_core_a  <= r_a;
                r_core_b  <= w_eff_b;
                r_cnt     <= '0;
            end else if (r_state == ST_CORE_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == ST_CLASS && w_fast) begin
                r_result               <= w_fast_result;
                r_flags                <= '0;
                r_flags[FLAG_FAST]     <= 1'b1;
                r_flags[FLAG_INVALID]  <= w_invalid;
            end else if (r_state == ST_CORE_WAIT && core_done_i) begin
                r_result <= core_result_i;
                r_flags  <= '0;
            end else if (r_state == ST_CORE_WAIT && w_timeout) begin
                r_result              <= BF16_QNAN;
                r_flags               <= '0;
                r_flags[FLAG_TIMEOUT] <= 1'b1;
            end
        end
    end

    // Core operands are live in the start cycle and held by registers afterwards.
    assign core_start_o  = w_dispatch;
    assign core_op_o     = w_dispatch ? w_dispatch_op : r_core_op;
    assign core_a_o      = w_dispatch ? r_a : r_core_a;
    assign core_b_o      = w_dispatch ? w_eff_b : r_core_b;

    assign req_ready_o   = w_req_ready;
    assign resp_valid_o  = (r_state == ST_RESP);
    assign resp_result_o = r_result;
    assign resp_tag_o    = r_tag;
    assign resp_flags_o  = r_flags;

endmodule
